// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encodings, access-width codes and IO address range for mem_ctrl.
// Rev 1.0
`default_nettype none

package mem_ctrl_pkg;

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_IF_RD = 3'd1;
  localparam logic [2:0] c_LS_RD = 3'd2;
  localparam logic [2:0] c_LS_WR = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  localparam logic [1:0] c_W_BYTE = 2'b00;
  localparam logic [1:0] c_W_HALF = 2'b01;
  localparam logic [1:0] c_W_WORD = 2'b10;

  // addr[17:16] value that selects the buffered IO space
  localparam logic [1:0] c_IO_RANGE = 2'b11;

  // Byte count of an access; the unused code 11 behaves as a word
  function automatic logic [2:0] nbytes(input logic [1:0] width);
    case (width)
      c_W_BYTE: return 3'd1;
      c_W_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ctrl.sv
// mem_ctrl: round-robin arbiter of instruction fetch and load/store onto one byte-serial RAM/IO port.
// Rev 1.0
`default_nettype none

module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_width,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic        clear,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  logic [2:0]  r_state;
  logic [2:0]  r_cnt;
  logic [2:0]  r_n;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic        r_last_ls;
  logic        r_frozen;
  logic [7:0]  r_skid;

  logic        w_grant_if;
  logic [2:0]  w_cnt_nx;
  logic [1:0]  w_sidx;
  logic [7:0]  w_byte;
  logic [31:0] w_asm;
  logic [31:0] w_wsh;
  logic        w_io_stall;
  logic        w_io_stall_new;

  assign w_grant_if     = if_req && !clear && (!ls_req || r_last_ls);
  assign w_cnt_nx       = r_cnt + 3'd1;
  assign w_sidx         = r_cnt[1:0] - 2'd1;
  assign w_wsh          = r_wdata >> {w_cnt_nx[1:0], 3'b000};
  assign w_io_stall     = (r_base[17:16] == c_IO_RANGE) && io_buffer_full;
  assign w_io_stall_new = (ls_addr[17:16] == c_IO_RANGE) && io_buffer_full;

  // The RAM keeps following the frozen address during a stall, so the byte due
  // at the first frozen edge is parked in r_skid and consumed on resume.
  assign w_byte = r_frozen ? r_skid : mem_din;

  always_comb begin
    w_asm = r_buf;
    case (w_sidx)
      2'd0: w_asm[7:0]   = w_byte;
      2'd1: w_asm[15:8]  = w_byte;
      2'd2: w_asm[23:16] = w_byte;
      2'd3: w_asm[31:24] = w_byte;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= c_IDLE;
      r_cnt     <= 3'd0;
      r_n       <= 3'd0;
      r_base    <= 32'd0;
      r_wdata   <= 32'd0;
      r_buf     <= 32'd0;
      r_last_ls <= 1'b1;
      r_frozen  <= 1'b0;
      r_skid    <= 8'd0;
      mem_a     <= 32'd0;
      mem_dout  <= 8'd0;
      mem_wr    <= 1'b0;
      if_done   <= 1'b0;
      ls_done   <= 1'b0;
      if_data   <= 32'd0;
      ls_rdata  <= 32'd0;
    end else if (!rdy) begin
      mem_wr   <= 1'b0;
      r_frozen <= 1'b1;
      if (!r_frozen) r_skid <= mem_din;
    end else begin
      r_frozen <= 1'b0;
      case (r_state)
        c_IDLE: begin
          r_cnt <= 3'd0;
          r_buf <= 32'd0;
          if (w_grant_if) begin
            r_state   <= c_IF_RD;
            r_base    <= if_addr;
            mem_a     <= if_addr;
            r_n       <= 3'd4;
            r_last_ls <= 1'b0;
          end else if (ls_req) begin
            r_state   <= ls_wr ? c_LS_WR : c_LS_RD;
            r_base    <= ls_addr;
            r_wdata   <= ls_wdata;
            mem_a     <= ls_addr;
            mem_dout  <= ls_wdata[7:0];
            mem_wr    <= ls_wr && !w_io_stall_new;
            r_n       <= nbytes(ls_width);
            r_last_ls <= 1'b1;
          end
        end
        c_IF_RD, c_LS_RD: begin
          if (clear && r_state == c_IF_RD) begin
            r_state <= c_IDLE;
            mem_wr  <= 1'b0;
          end else begin
            if (r_cnt != 3'd0) r_buf <= w_asm;
            if (w_cnt_nx < r_n) mem_a <= r_base + {29'd0, w_cnt_nx};
            if (r_cnt == r_n) begin
              r_state <= c_DONE;
              if (r_state == c_IF_RD) begin
                if_done <= 1'b1;
                if_data <= w_asm;
              end else begin
                ls_done  <= 1'b1;
                ls_rdata <= w_asm;
              end
            end else begin
              r_cnt <= w_cnt_nx;
            end
          end
        end
        c_LS_WR: begin
          // mem_wr high means byte r_cnt is being written at this edge
          if (!mem_wr) begin
            mem_wr <= !w_io_stall;
          end else if (w_cnt_nx == r_n) begin
            mem_wr  <= 1'b0;
            ls_done <= 1'b1;
            r_state <= c_DONE;
          end else begin
            r_cnt    <= w_cnt_nx;
            mem_a    <= r_base + {29'd0, w_cnt_nx};
            mem_dout <= w_wsh[7:0];
            mem_wr   <= !w_io_stall;
          end
        end
        c_DONE: begin
          if_done <= 1'b0;
          ls_done <= 1'b0;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vector table plus hand sequences for arbitration, IO stall, clear, rdy and reset.
// Rev 1.0
`default_nettype none

module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req = 1'b0;
  logic        ls_wr = 1'b0;
  logic [31:0] ls_addr = 32'd0;
  logic [1:0]  ls_width = 2'b00;
  logic [31:0] ls_wdata = 32'd0;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        clear = 1'b0;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int tests = 0;
  int fails = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_width(ls_width),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .clear(clear), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: unwritten bytes read addr[7:0]^5A, except the fetch word at 0x1000
  logic [31:0] wlog_a [64];
  logic [7:0]  wlog_d [64];
  int          wn = 0;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    for (int i = wn - 1; i >= 0; i--)
      if (wlog_a[i] == a) return wlog_d[i];
    case (a)
      32'h1000: return 8'h13;
      32'h1001: return 8'h05;
      32'h1002: return 8'h00;
      32'h1003: return 8'h00;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr && wn < 64) begin
      wlog_a[wn] <= mem_a;
      wlog_d[wn] <= mem_dout;
      wn <= wn + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          is_if;
    bit          wr;
    logic [1:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [13];

  task automatic do_txn(input vec_t v, input int id);
    int n, lat, exp_lat;
    bit addr_ok, wr_ok, other;
    logic [31:0] got, sh;
    n = v.is_if ? 4 : (v.w == 2'b00 ? 1 : (v.w == 2'b01 ? 2 : 4));
    exp_lat = (!v.is_if && v.wr) ? n : n + 1;
    @(negedge clk);
    if (v.is_if) begin
      if_req = 1'b1; if_addr = v.a;
    end else begin
      ls_req = 1'b1; ls_wr = v.wr; ls_addr = v.a; ls_width = v.w; ls_wdata = v.d;
    end
    @(posedge clk);
    lat = -1; addr_ok = 1'b1; wr_ok = 1'b1; other = 1'b0; got = 32'd0;
    for (int k = 0; k < 16 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin if_req = 1'b0; ls_req = 1'b0; end
      if (k < n) begin
        if (mem_a !== v.a + 32'(k)) addr_ok = 1'b0;
        if (!v.is_if && v.wr) begin
          sh = v.d >> (8 * k);
          if (mem_wr !== 1'b1 || mem_dout !== sh[7:0]) wr_ok = 1'b0;
        end
      end
      if ((v.is_if || !v.wr) && mem_wr !== 1'b0) wr_ok = 1'b0;
      if (v.is_if ? ls_done : if_done) other = 1'b1;
      if (v.is_if ? if_done : ls_done) begin
        lat = k;
        got = v.is_if ? if_data : ls_rdata;
      end
    end
    chk($sformatf("v%0d_latency", id), 32'(lat), 32'(exp_lat));
    chk($sformatf("v%0d_addr_seq", id), {31'd0, addr_ok}, 32'd1);
    chk($sformatf("v%0d_mem_wr", id), {31'd0, wr_ok}, 32'd1);
    chk($sformatf("v%0d_other_done", id), {31'd0, other}, 32'd0);
    if (v.is_if || !v.wr) chk($sformatf("v%0d_data", id), got, v.exp);
    @(negedge clk);
    chk($sformatf("v%0d_pulse", id), {30'd0, if_done, ls_done}, 32'd0);
  endtask

  initial begin
    int fi, fl, nwr, wk, ifd;
    bit both;
    logic [31:0] a0, d_if, d_ls, wa;
    logic [7:0]  wd;

    vt[0]  = '{1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'h0,          32'h0000_0513};
    vt[1]  = '{1'b0, 1'b0, 2'b10, 32'h0000_2000, 32'h0,          32'h5958_5B5A};
    vt[2]  = '{1'b0, 1'b0, 2'b01, 32'h0000_2002, 32'h0,          32'h0000_5958};
    vt[3]  = '{1'b0, 1'b0, 2'b00, 32'h0000_2003, 32'h0,          32'h0000_0059};
    vt[4]  = '{1'b0, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,          32'h5B5A_A5A4};
    vt[5]  = '{1'b0, 1'b1, 2'b10, 32'h0000_4000, 32'hDEAD_BEEF,  32'h0};
    vt[6]  = '{1'b0, 1'b0, 2'b10, 32'h0000_4000, 32'h0,          32'hDEAD_BEEF};
    vt[7]  = '{1'b0, 1'b1, 2'b01, 32'h0000_4005, 32'hFFFF_1234,  32'h0};
    vt[8]  = '{1'b0, 1'b0, 2'b10, 32'h0000_4004, 32'h0,          32'h5D12_345E};
    vt[9]  = '{1'b0, 1'b1, 2'b11, 32'h0000_5000, 32'hCAFE_F00D,  32'h0};
    vt[10] = '{1'b0, 1'b0, 2'b10, 32'h0000_5000, 32'h0,          32'hCAFE_F00D};
    vt[11] = '{1'b0, 1'b0, 2'b00, 32'h0003_0000, 32'h0,          32'h0000_00AB};
    vt[12] = '{1'b1, 1'b0, 2'b10, 32'h0000_2000, 32'h0,          32'h5958_5B5A};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_ctrl", {21'd0, mem_wr, if_done, ls_done, mem_dout}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    rst = 1'b1;

    // Simultaneous requests straight after reset: IF first, then LS
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h1000;
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h2000; ls_width = 2'b10;
    @(posedge clk);
    fi = -1; fl = -1; both = 1'b0; a0 = 32'd0; d_if = 32'd0; d_ls = 32'd0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) a0 = mem_a;
      if (if_done && ls_done) both = 1'b1;
      if (if_done && fi < 0) begin fi = k; d_if = if_data; if_req = 1'b0; end
      if (ls_done && fl < 0) begin fl = k; d_ls = ls_rdata; ls_req = 1'b0; end
    end
    if_req = 1'b0; ls_req = 1'b0;
    chk("rr_first_addr", a0, 32'h1000);
    chk("rr_if_done_at", 32'(fi), 32'd5);
    chk("rr_ls_done_at", 32'(fl), 32'd12);
    chk("rr_if_data", d_if, 32'h0000_0513);
    chk("rr_ls_data", d_ls, 32'h5958_5B5A);
    chk("rr_both_done", {31'd0, both}, 32'd0);

    // IO store stalled by a full buffer for three cycles
    @(negedge clk);
    ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h0003_0000; ls_width = 2'b00;
    ls_wdata = 32'h0000_00AB; io_buffer_full = 1'b1;
    @(posedge clk);
    nwr = 0; wk = -1; fl = -1; wa = 32'd0; wd = 8'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) ls_req = 1'b0;
      if (k == 2) io_buffer_full = 1'b0;
      if (mem_wr) begin nwr++; wk = k; wa = mem_a; wd = mem_dout; end
      if (ls_done && fl < 0) fl = k;
    end
    ls_wr = 1'b0;
    chk("io_write_count", 32'(nwr), 32'd1);
    chk("io_write_cycle", 32'(wk), 32'd3);
    chk("io_write_addr", wa, 32'h0003_0000);
    chk("io_write_data", {24'd0, wd}, 32'h0000_00AB);
    chk("io_done_at", 32'(fl), 32'd4);

    // Clear aborts a fetch; the following load is granted at once
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h1000;
    @(posedge clk);
    ifd = 0; fl = -1; a0 = 32'd0; d_ls = 32'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) if_req = 1'b0;
      if (k == 1) clear = 1'b1;
      if (k == 2) begin
        clear = 1'b0; ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h2101; ls_width = 2'b00;
      end
      if (k == 3) begin a0 = mem_a; ls_req = 1'b0; end
      if (if_done) ifd++;
      if (ls_done && fl < 0) begin fl = k; d_ls = ls_rdata; end
    end
    chk("clr_no_if_done", 32'(ifd), 32'd0);
    chk("clr_ls_grant_addr", a0, 32'h2101);
    chk("clr_ls_done_at", 32'(fl), 32'd5);
    chk("clr_ls_data", d_ls, 32'h0000_005B);

    // rdy low for two edges inside a half-word load
    @(negedge clk);
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h2002; ls_width = 2'b01;
    @(posedge clk);
    fl = -1; nwr = 0; d_ls = 32'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) ls_req = 1'b0;
      if (k == 1) rdy = 1'b0;
      if (k == 3) rdy = 1'b1;
      if (ls_done) nwr++;
      if (ls_done && fl < 0) begin fl = k; d_ls = ls_rdata; end
    end
    chk("rdy_done_at", 32'(fl), 32'd5);
    chk("rdy_done_count", 32'(nwr), 32'd1);
    chk("rdy_ls_data", d_ls, 32'h0000_5958);

    // Directed vector table
    foreach (vt[i]) do_txn(vt[i], i);

    // Reset in the middle of a fetch abandons it
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h2000;
    @(posedge clk);
    ifd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) if_req = 1'b0;
      if (k == 1) rst = 1'b0;
      if (k == 2) begin
        rst = 1'b1;
        chk("rst_mid_mem_a", mem_a, 32'd0);
      end
      if (if_done) ifd++;
    end
    chk("rst_mid_no_done", 32'(ifd), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
